// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: word/opcode types, memory-op and MEM-stage state
// encodings, and the word-granular address compare used by LL/SC.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_LW    = 6'h23;
    localparam opcode_t OP_SW    = 6'h2b;
    localparam opcode_t OP_LL    = 6'h30;
    localparam opcode_t OP_SC    = 6'h38;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } memop_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_REQ  = 2'b01,
        MS_DONE = 2'b10
    } memstate_t;

    // Byte offset is ignored: links and snoops cover a whole word.
    function automatic logic word_eq(input word_t a, input word_t b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/mem_stage_llsc_link.sv
// LL/SC link register: set on LL completion, cleared by SC, stores to the
// linked word and matching snoops; a snoop always beats a same-cycle set.
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  set_i,
    input  word_t set_addr_i,
    input  logic  clr_i,
    input  logic  st_i,
    input  word_t st_addr_i,
    input  logic  snoop_valid_i,
    input  word_t snoop_addr_i,
    input  word_t chk_addr_i,
    output logic  sc_match_o,
    output logic  link_valid_o,
    output word_t link_addr_o
);

    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    // Next link state; the snoop compare uses the post-update address so it
    // also kills a link being established in the same cycle.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = set_addr_i;
        end else if (clr_i) begin
            valid_d = 1'b0;
        end else if (st_i && word_eq(st_addr_i, addr_q)) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        if (snoop_valid_i && word_eq(snoop_addr_i, addr_d)) begin
            valid_d = 1'b0;
        end else begin
            addr_d = addr_d;
        end
    end

    // Link registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            addr_q  <= 32'h0000_0000;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign sc_match_o   = valid_q && word_eq(addr_q, chk_addr_i);
    assign link_valid_o = valid_q;
    assign link_addr_o  = addr_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registered dcache request/hit handshake, pipeline stall
// while an access is outstanding, LL/SC handling and MEMWB result muxing.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    ex_valid,
    input  opcode_t opcode,
    input  logic [1:0] mem_op,
    input  word_t   addr,
    input  word_t   store_data,
    input  logic    dhit,
    input  word_t   dload,
    input  logic    snoop_valid,
    input  word_t   snoop_addr,
    output logic    dmemREN,
    output logic    dmemWEN,
    output word_t   dmemaddr,
    output word_t   dmemstore,
    output logic    mem_stall,
    output logic    wb_valid,
    output word_t   wb_data
);

    memstate_t state_q, state_d;
    logic      ren_q, ren_d, wen_q, wen_d;
    logic      is_ll_q, is_ll_d, is_sc_q, is_sc_d;
    word_t     maddr_q, maddr_d, mstore_q, mstore_d, rdata_q, rdata_d;
    logic      is_load_s, is_store_s, is_ll_op_s, is_sc_op_s, sc_match_s;
    logic      link_set_s, link_clr_s, st_done_s;
    logic      link_valid_s;
    word_t     link_addr_s;

    assign is_load_s  = (mem_op == MEM_LOAD);
    assign is_store_s = (mem_op == MEM_STORE);
    assign is_ll_op_s = is_load_s && (opcode == OP_LL);
    assign is_sc_op_s = is_store_s && (opcode == OP_SC);

    // FSM next state, request registers, and stall/writeback outputs.
    always_comb begin
        state_d    = state_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        maddr_d    = maddr_q;
        mstore_d   = mstore_q;
        rdata_d    = rdata_q;
        is_ll_d    = is_ll_q;
        is_sc_d    = is_sc_q;
        mem_stall  = 1'b0;
        wb_valid   = 1'b0;
        wb_data    = addr;
        link_set_s = 1'b0;
        link_clr_s = 1'b0;
        st_done_s  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                if (ex_valid && is_sc_op_s && !sc_match_s) begin
                    wb_valid   = 1'b1;
                    wb_data    = 32'h0000_0000;
                    link_clr_s = 1'b1;
                end else if (ex_valid && (is_load_s || is_store_s)) begin
                    mem_stall = 1'b1;
                    maddr_d   = addr;
                    mstore_d  = store_data;
                    ren_d     = is_load_s;
                    wen_d     = is_store_s;
                    is_ll_d   = is_ll_op_s;
                    is_sc_d   = is_sc_op_s;
                    state_d   = MS_REQ;
                end else begin
                    wb_valid = ex_valid;
                    wb_data  = addr;
                end
            end
            MS_REQ: begin
                mem_stall = 1'b1;
                if (dhit) begin
                    ren_d      = 1'b0;
                    wen_d      = 1'b0;
                    state_d    = MS_DONE;
                    link_set_s = is_ll_q;
                    link_clr_s = is_sc_q;
                    st_done_s  = wen_q && !is_sc_q;
                    if (ren_q) begin
                        rdata_d = dload;
                    end else if (is_sc_q) begin
                        rdata_d = 32'h0000_0001;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = MS_REQ;
                end
            end
            MS_DONE: begin
                wb_valid = 1'b1;
                wb_data  = rdata_q;
                state_d  = MS_IDLE;
            end
            default: begin
                state_d = MS_IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    // State and request registers; reset abandons any outstanding request.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= MS_IDLE;
            ren_q    <= 1'b0;
            wen_q    <= 1'b0;
            maddr_q  <= 32'h0000_0000;
            mstore_q <= 32'h0000_0000;
            rdata_q  <= 32'h0000_0000;
            is_ll_q  <= 1'b0;
            is_sc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ren_q    <= ren_d;
            wen_q    <= wen_d;
            maddr_q  <= maddr_d;
            mstore_q <= mstore_d;
            rdata_q  <= rdata_d;
            is_ll_q  <= is_ll_d;
            is_sc_q  <= is_sc_d;
        end
    end

    llsc_link u_link (
        .CLK           (CLK),
        .RST           (RST),
        .set_i         (link_set_s),
        .set_addr_i    (maddr_q),
        .clr_i         (link_clr_s),
        .st_i          (st_done_s),
        .st_addr_i     (maddr_q),
        .snoop_valid_i (snoop_valid),
        .snoop_addr_i  (snoop_addr),
        .chk_addr_i    (addr),
        .sc_match_o    (sc_match_s),
        .link_valid_o  (link_valid_s),
        .link_addr_o   (link_addr_s)
    );

    assign dmemREN   = ren_q;
    assign dmemWEN   = wen_q;
    assign dmemaddr  = maddr_q;
    assign dmemstore = mstore_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: driver issues instructions and pushes the
// expected writeback into a queue; a negedge monitor pops and compares.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       ex_valid = 1'b0;
    opcode_t    opcode = OP_RTYPE;
    logic [1:0] mem_op = 2'b00;
    word_t      addr = 32'h0;
    word_t      store_data = 32'h0;
    logic       dhit = 1'b0;
    word_t      dload = 32'h0;
    logic       snoop_valid = 1'b0;
    word_t      snoop_addr = 32'h0;
    logic       dmemREN, dmemWEN, mem_stall, wb_valid;
    word_t      dmemaddr, dmemstore, wb_data;

    typedef struct {
        logic  chk;
        word_t data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;

    mem_stage dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .opcode(opcode),
        .mem_op(mem_op), .addr(addr), .store_data(store_data),
        .dhit(dhit), .dload(dload), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_stall(mem_stall),
        .wb_valid(wb_valid), .wb_data(wb_data)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input word_t act, input word_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every writeback must match the oldest expectation.
    always @(negedge CLK) begin
        if (!RST && wb_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got 0x%08h expected none", wb_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (e.chk) check("wb_data", wb_data, e.data);
            end
        end
    end

    // Issue one instruction and hold it in EXMEM until the stage stops stalling.
    task automatic run(input opcode_t op, input logic [1:0] mop, input word_t a,
                       input word_t sd, input int hit_at, input word_t ld,
                       input int snoop_at, input word_t saddr,
                       input logic chk, input word_t exp_wb, input int exp_stall);
        int   stalls = 0;
        int   req = 0;
        logic done = 1'b0;
        logic exp_ren = (mop == 2'b01);
        logic exp_wen = (mop == 2'b10);
        sb_q.push_back('{chk, exp_wb});
        ex_valid = 1'b1; opcode = op; mem_op = mop; addr = a; store_data = sd;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge CLK);
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                dhit = 1'b0;
                snoop_valid = 1'b0;
                if (dmemREN || dmemWEN) begin
                    req++;
                    check("req_ren", {31'd0, dmemREN}, {31'd0, exp_ren});
                    check("req_wen", {31'd0, dmemWEN}, {31'd0, exp_wen});
                    check("req_addr", dmemaddr, a);
                    if (exp_wen) check("req_store", dmemstore, sd);
                    if (req == hit_at) begin
                        dhit = 1'b1;
                        dload = ld;
                    end
                    if (req == snoop_at) begin
                        snoop_valid = 1'b1;
                        snoop_addr = saddr;
                    end
                end
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout: op=0x%02h addr=0x%08h still stalling", op, a);
        end
        check("stall_cycles", stalls, exp_stall);
        @(posedge CLK);
        #1;
        ex_valid = 1'b0; mem_op = 2'b00; dhit = 1'b0; snoop_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("rst_ren", {31'd0, dmemREN}, 32'd0);
        check("rst_wen", {31'd0, dmemWEN}, 32'd0);
        check("rst_addr", dmemaddr, 32'h0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge CLK); #1;

        // op, mop, addr, store, hit_at, dload, snoop_at, snoop_addr, chk, wb, stalls
        run(OP_RTYPE, 2'b00, 32'h1234, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1, 32'h1234, 0);
        run(OP_RTYPE, 2'b11, 32'hABCD, 32'h0, 0, 32'h0, 0, 32'h0, 1'b1, 32'hABCD, 0);
        run(OP_LW, 2'b01, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0, 32'h0, 1'b1, 32'hDEADBEEF, 4);
        run(OP_LW, 2'b01, 32'h104, 32'h0, 1, 32'h0BADF00D, 0, 32'h0, 1'b1, 32'h0BADF00D, 2);
        // LL then successful SC, then SC again fails because the link is gone
        run(OP_LL, 2'b01, 32'h200, 32'h0, 1, 32'h77, 0, 32'h0, 1'b1, 32'h77, 2);
        run(OP_SC, 2'b10, 32'h200, 32'h5, 2, 32'h0, 0, 32'h0, 1'b1, 32'h1, 3);
        run(OP_SC, 2'b10, 32'h200, 32'h6, 0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0);
        // Snoop to same word (different byte) while idle kills the link
        run(OP_LL, 2'b01, 32'h200, 32'h0, 1, 32'h11, 0, 32'h0, 1'b1, 32'h11, 2);
        snoop_valid = 1'b1; snoop_addr = 32'h202;
        @(posedge CLK); #1 snoop_valid = 1'b0;
        run(OP_SC, 2'b10, 32'h200, 32'h7, 0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0);
        // Snoop on the LL dhit cycle wins over the link set
        run(OP_LL, 2'b01, 32'h300, 32'h0, 2, 32'h22, 2, 32'h300, 1'b1, 32'h22, 3);
        run(OP_SC, 2'b10, 32'h300, 32'h8, 0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0);
        // Plain store to the linked word clears the link
        run(OP_LL, 2'b01, 32'h400, 32'h0, 1, 32'h33, 0, 32'h0, 1'b1, 32'h33, 2);
        run(OP_SW, 2'b10, 32'h400, 32'h9, 1, 32'h0, 0, 32'h0, 1'b0, 32'h0, 2);
        run(OP_SC, 2'b10, 32'h400, 32'hA, 0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0);
        // Snoop after SC issue does not change its result; link ends cleared
        run(OP_LL, 2'b01, 32'h500, 32'h0, 1, 32'h44, 0, 32'h0, 1'b1, 32'h44, 2);
        run(OP_SC, 2'b10, 32'h503, 32'hB, 1, 32'h0, 1, 32'h500, 1'b1, 32'h1, 2);
        run(OP_SC, 2'b10, 32'h500, 32'hC, 0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0);

        // Reset in the middle of a store request
        run(OP_LL, 2'b01, 32'h600, 32'h0, 1, 32'h55, 0, 32'h0, 1'b1, 32'h55, 2);
        ex_valid = 1'b1; opcode = OP_SW; mem_op = 2'b10; addr = 32'h600; store_data = 32'hD;
        @(posedge CLK);
        @(negedge CLK);
        check("mid_wen", {31'd0, dmemWEN}, 32'd1);
        RST = 1'b1; ex_valid = 1'b0; mem_op = 2'b00;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        check("post_rst_ren", {31'd0, dmemREN}, 32'd0);
        check("post_rst_wen", {31'd0, dmemWEN}, 32'd0);
        check("post_rst_addr", dmemaddr, 32'h0);
        check("post_rst_store", dmemstore, 32'h0);
        check("post_rst_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge CLK); #1;
        run(OP_SC, 2'b10, 32'h600, 32'hE, 0, 32'h0, 0, 32'h0, 1'b1, 32'h0, 0);

        repeat (3) @(posedge CLK);
        check("sb_empty", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, between the EXMEM latch and the MEMWB latch. It turns the memory operation held in EXMEM into a registered request/hit handshake with the data cache, stalls the pipeline while the access is outstanding, and keeps the per-core LL/SC link register, including snoop invalidation. It then presents one completed result per instruction to the MEMWB latch.

## Interface
Parameters:
- none; word width and types come from `cpu_types_pkg`.

Ports:
- `CLK` in 1: pipeline clock.
- `RST` in 1: reset. One clock; reset is synchronous and active-high.
- `ex_valid` in 1: EXMEM holds a valid instruction.
- `opcode` in `opcode_t`: opcode from EXMEM; LL and SC are distinguished here.
- `mem_op` in 2: memory op. 00 none, 01 load, 10 store; 11 is treated as none.
- `addr` in `word_t`: ALU result, which is the memory address or the value to pass through.
- `store_data` in `word_t`: rt value for stores.
- `dhit` in 1: cache completes the current request.
- `dload` in `word_t`: load data, valid when `dhit`=1.
- `snoop_valid` in 1: a coherence invalidation is presented this cycle.
- `snoop_addr` in `word_t`: invalidated address.
- `dmemREN` out 1: read request (registered).
- `dmemWEN` out 1: write request (registered).
- `dmemaddr` out `word_t`: request address (registered).
- `dmemstore` out `word_t`: write data (registered).
- `mem_stall` out 1: freeze PC, IFID, IDEX and EXMEM, and flush MEMWB this cycle.
- `wb_valid` out 1: `wb_data` is final; MEMWB captures it at the next edge.
- `wb_data` out `word_t`: value destined for MEMWB `alu_out_i`.

## Operation
- States: IDLE, REQ, DONE.
- IDLE, non-memory instruction (`mem_op`=00 or 11):
  - `wb_valid`=`ex_valid`, `wb_data`=`addr`, combinational.
  - `mem_stall`=0.
- IDLE, LW/SW/LL, or SC with a matching link:
  - `mem_stall`=1.
  - Load `dmemaddr`←`addr` and `dmemstore`←`store_data`.
  - Set REN (load) or WEN (store) for the next cycle; go to REQ.
- SC is accepted when `link_valid` && `link_addr[31:2]`==`addr[31:2]`. The decision is made in the IDLE cycle only.
- Failing SC:
  - No cache access, no stall.
  - `wb_valid`=1 and `wb_data`=0 in the IDLE cycle; the link is cleared.
- REQ:
  - Hold REN/WEN, address and data stable until `dhit`.
  - On `dhit`: drop REN/WEN at the edge, capture `dload` (loads) or the constant 1 (successful SC) into `rdata`, go to DONE.
  - `mem_stall`=1 throughout.
- DONE: `mem_stall`=0, `wb_valid`=1, `wb_data`=`rdata`; go to IDLE unconditionally.
- Link register updates:
  - LL completion sets `link_valid`=1 and `link_addr`=`dmemaddr`.
  - SC completion clears the link.
  - SW completion to the linked word clears the link.
- Snoop: `snoop_valid` with `snoop_addr[31:2]`==`link_addr[31:2]` clears `link_valid` in any state.
- Snoop in the same cycle as LL completion to the same word: the snoop wins and `link_valid` stays 0.
- Snoop after an SC has been issued (state REQ) does not change that SC's result; the link ends cleared.
- Address compare is word granular: bits [1:0] are ignored.

## Timing
- Reset (edge with `RST`=1), from any state including mid-REQ:
  - State IDLE.
  - `dmemREN`=`dmemWEN`=0, `dmemaddr`=`dmemstore`=0.
  - `rdata`=0, `link_valid`=0, `link_addr`=0.
  - The outstanding request is abandoned.
- Non-memory instruction: 0 stall cycles.
- Memory access: request visible 1 cycle after EXMEM presents it. Total stall = 1 + N cycles, where N = number of REQ cycles up to and including the `dhit` cycle (N≥1). DONE follows.
- Zero-wait cache (`dhit` in the first REQ cycle): 2 stall cycles, 3 cycles in MEM.
- `dhit` is ignored in IDLE and DONE.
- REN and WEN are never asserted together.
- The same EXMEM contents are held during stall; the block reads them only in IDLE.

## Structure
- `cpu_types_pkg` gains:
  - `memop_t` (NONE/LOAD/STORE).
  - `memstate_t` (IDLE/REQ/DONE).
  - LL/SC opcode constants, if not already present.
- Sub-module `llsc_link`: link valid/address registers, snoop compare, set/clear priority, and SC-match output.
- FSM, request registers and stall/writeback muxing stay in `mem_stage`.

## Test plan
- ADDU with `addr`=0x1234, `mem_op`=00 → `wb_valid`=1, `wb_data`=0x1234 in the same cycle, `mem_stall`=0.
- LW at 0x100, `dhit` after 3 REQ cycles, `dload`=0xDEADBEEF:
  - `dmemREN`=1 and `dmemaddr`=0x100 for 3 cycles, `mem_stall`=1 for 4 cycles.
  - DONE gives `wb_data`=0xDEADBEEF.
- LL at 0x200, then SC at 0x200 with `store_data`=5:
  - `dmemWEN`=1 and `dmemstore`=5.
  - `wb_data`=1; the link is cleared afterwards.
- LL at 0x200, `snoop_valid` with `snoop_addr`=0x202, then SC at 0x200 → no WEN, no stall, `wb_data`=0.
- LL at 0x300 with `snoop_valid` and `snoop_addr`=0x300 on its `dhit` cycle → SC at 0x300 fails with `wb_data`=0.
- SW in REQ, then `RST` for one cycle → the next cycle has REN=WEN=0, state IDLE, link invalid, and a following SC fails.
